// File: rtl/pwm_multichannel_peripheral.sv
// ============================================================================
// Module   : pwm_multichannel_peripheral
// Brief    : N-channel PWM generator with prescaler, programmable period and
//            per-channel duty; period/duty are double-buffered and commit at wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_multichannel_peripheral #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [7:0]        cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  output logic [CNT_W-1:0]  cfg_rdata,
  output logic              cfg_rvalid,
  output logic [NUM_CH-1:0] out,
  output logic              period_wrap
);

  localparam int c_PBITS = (PRESC_W < CNT_W) ? PRESC_W : CNT_W;

  logic               r_en;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_presc_cnt;
  logic [CNT_W-1:0]   r_period_pend;
  logic [CNT_W-1:0]   r_period_act;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_CH-1:0]  r_out_en;
  logic [NUM_CH-1:0]  r_pwm_en;
  logic [CNT_W-1:0]   r_duty_pend [NUM_CH];
  logic [CNT_W-1:0]   r_duty_act  [NUM_CH];
  logic [NUM_CH-1:0]  r_out;
  logic               r_wrap;
  logic [CNT_W-1:0]   r_rdata;
  logic               r_rvalid;

  logic [31:0]        w_oe32;
  logic [31:0]        w_pe32;
  logic [CNT_W-1:0]   w_rdata;
  logic               w_tick;
  logic               w_wrap;

  generate
    if (NUM_CH < 32) begin : g_pad_en
      assign w_oe32 = {{(32-NUM_CH){1'b0}}, r_out_en};
      assign w_pe32 = {{(32-NUM_CH){1'b0}}, r_pwm_en};
    end else begin : g_full_en
      assign w_oe32 = r_out_en;
      assign w_pe32 = r_pwm_en;
    end
  endgenerate

  assign w_tick = r_en && (r_presc_cnt == r_presc);
  assign w_wrap = w_tick && (r_cnt == r_period_act);

  // Reads always see pending values; a same-cycle write lands after this sample.
  always_comb begin
    w_rdata = '0;
    case (cfg_addr)
      8'h00: w_rdata[0] = r_en;
      8'h01: w_rdata[c_PBITS-1:0] = r_presc[c_PBITS-1:0];
      8'h02: w_rdata = r_period_pend;
      8'h04, 8'h05, 8'h06, 8'h07: w_rdata[7:0] = w_oe32[{cfg_addr[1:0], 3'b000} +: 8];
      8'h08, 8'h09, 8'h0A, 8'h0B: w_rdata[7:0] = w_pe32[{cfg_addr[1:0], 3'b000} +: 8];
      default: ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_addr == 8'(16 + i)) w_rdata = r_duty_pend[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en          <= 1'b0;
      r_presc       <= '0;
      r_presc_cnt   <= '0;
      r_period_pend <= '1;
      r_period_act  <= '1;
      r_cnt         <= '0;
      r_out_en      <= '0;
      r_pwm_en      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty_pend[i] <= '0;
        r_duty_act[i]  <= '0;
      end
      r_out    <= '0;
      r_wrap   <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          8'h00: r_en <= cfg_wdata[0];
          8'h01: begin
            r_presc                <= '0;
            r_presc[c_PBITS-1:0]   <= cfg_wdata[c_PBITS-1:0];
          end
          8'h02: r_period_pend <= cfg_wdata;
          default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
          if (cfg_addr == 8'(4 + i / 8))  r_out_en[i]    <= cfg_wdata[i % 8];
          if (cfg_addr == 8'(8 + i / 8))  r_pwm_en[i]    <= cfg_wdata[i % 8];
          if (cfg_addr == 8'(16 + i))     r_duty_pend[i] <= cfg_wdata;
        end
      end

      if (!r_en) begin
        r_presc_cnt  <= '0;
        r_cnt        <= '0;
        r_period_act <= r_period_pend;
        for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= r_duty_pend[i];
        r_wrap       <= 1'b0;
      end else begin
        r_wrap <= w_wrap;
        if (w_tick) begin
          r_presc_cnt <= '0;
          if (w_wrap) begin
            r_cnt        <= '0;
            r_period_act <= r_period_pend;
            for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= r_duty_pend[i];
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else if (r_presc_cnt > r_presc) begin
          // PRESC was lowered below the running count: restart without a tick
          r_presc_cnt <= '0;
        end else begin
          r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
        end
      end

      for (int i = 0; i < NUM_CH; i++) begin
        r_out[i] <= r_out_en[i] & (~r_pwm_en[i] | (r_en & (r_cnt < r_duty_act[i])));
      end

      r_rvalid <= cfg_re;
      if (cfg_re) r_rdata <= w_rdata;
    end
  end

  assign out         = r_out;
  assign period_wrap = r_wrap;
  assign cfg_rdata   = r_rdata;
  assign cfg_rvalid  = r_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_pwm_multichannel_peripheral.sv
// ============================================================================
// Module   : tb_pwm_multichannel_peripheral
// Brief    : Directed, table-driven self-checking bench for the PWM peripheral.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_multichannel_peripheral;

  localparam int NUM_CH = 16;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic              cfg_re;
  logic [7:0]        cfg_addr;
  logic [CNT_W-1:0]  cfg_wdata;
  logic [CNT_W-1:0]  cfg_rdata;
  logic              cfg_rvalid;
  logic [NUM_CH-1:0] out;
  logic              period_wrap;

  int checks = 0;
  int errors = 0;

  pwm_multichannel_peripheral #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_re     (cfg_re),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .cfg_rvalid (cfg_rvalid),
    .out        (out),
    .period_wrap(period_wrap)
  );

  always #5 clk = ~clk;

  // Period monitor: per wrap, the clocks since the previous wrap and high samples of ch_sel
  int ch_sel   = 0;
  int mon_cyc  = 0;
  int mon_hi   = 0;
  int last_gap = 0;
  int last_hi  = 0;
  int wraps    = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      mon_cyc = 0;
      mon_hi  = 0;
    end else begin
      mon_cyc++;
      if (out[ch_sel]) mon_hi++;
      if (period_wrap) begin
        last_gap = mon_cyc;
        last_hi  = mon_hi;
        mon_cyc  = 0;
        mon_hi   = 0;
        wraps++;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    cfg_re   = 1'b1;
    cfg_addr = a;
    @(posedge clk);
    #1;
    cfg_re = 1'b0;
    chk("rvalid", cfg_rvalid, 1);
    d = cfg_rdata;
  endtask

  task automatic wait_wraps(input int n);
    int target;
    int i;
    target = wraps + n;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (wraps >= target) break;
    end
    if (i == 3000) begin
      errors++;
      $display("FAIL wrap_timeout actual=%0d expected=%0d", wraps, target);
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [16];
  logic [7:0] rd;

  initial begin
    vecs[0]  = '{8'h00, 8'hFF, 8'h01};
    vecs[1]  = '{8'h01, 8'h05, 8'h05};
    vecs[2]  = '{8'h02, 8'h3C, 8'h3C};
    vecs[3]  = '{8'h03, 8'hAA, 8'h00};
    vecs[4]  = '{8'h04, 8'hA5, 8'hA5};
    vecs[5]  = '{8'h05, 8'h5A, 8'h5A};
    vecs[6]  = '{8'h06, 8'hFF, 8'h00};
    vecs[7]  = '{8'h07, 8'hFF, 8'h00};
    vecs[8]  = '{8'h08, 8'h0F, 8'h0F};
    vecs[9]  = '{8'h09, 8'hF0, 8'hF0};
    vecs[10] = '{8'h0B, 8'hFF, 8'h00};
    vecs[11] = '{8'h0C, 8'h77, 8'h00};
    vecs[12] = '{8'h10, 8'h80, 8'h80};
    vecs[13] = '{8'h1F, 8'h33, 8'h33};
    vecs[14] = '{8'h20, 8'h44, 8'h00};
    vecs[15] = '{8'hFF, 8'h12, 8'h00};

    rst = 1'b1; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0;

    // Reset state
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_out", out, 0);
      chk("rst_wrap", period_wrap, 0);
      chk("rst_rvalid", cfg_rvalid, 0);
      chk("rst_rdata", cfg_rdata, 0);
    end
    @(negedge clk); rst = 1'b0;
    read_reg(8'h02, rd); chk("rst_period", rd, 8'hFF);
    read_reg(8'h10, rd); chk("rst_duty0", rd, 8'h00);

    // Register map
    for (int i = 0; i < 16; i++) begin
      write_reg(vecs[i].addr, vecs[i].wdata);
      read_reg(vecs[i].addr, rd);
      chk($sformatf("regmap_%02h", vecs[i].addr), rd, vecs[i].exp);
    end

    // Simultaneous write and read returns the old value
    write_reg(8'h11, 8'h11);
    @(negedge clk);
    cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 8'h11; cfg_wdata = 8'h22;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_re = 1'b0;
    chk("wr_rd_old", cfg_rdata, 8'h11);
    @(posedge clk); #1;
    chk("rvalid_pulse", cfg_rvalid, 0);
    read_reg(8'h11, rd); chk("wr_rd_new", rd, 8'h22);

    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Static outputs with global enable off
    write_reg(8'h04, 8'h0F);
    @(posedge clk); #1;
    chk("static_on", out, 16'h000F);
    write_reg(8'h04, 8'h00);
    chk("static_lag", out, 16'h000F);
    @(posedge clk); #1;
    chk("static_off", out, 16'h0000);

    // Basic PWM
    write_reg(8'h01, 8'd0);
    write_reg(8'h02, 8'd255);
    write_reg(8'h10, 8'd128);
    write_reg(8'h04, 8'h01);
    write_reg(8'h08, 8'h01);
    ch_sel = 0;
    write_reg(8'h00, 8'h01);
    wait_wraps(2);
    chk("basic_period", last_gap, 256);
    chk("basic_high", last_hi, 128);

    // Prescaled PWM on ch5, including 0% and 100% duty
    write_reg(8'h00, 8'h00);
    write_reg(8'h01, 8'd3);
    write_reg(8'h02, 8'd9);
    write_reg(8'h15, 8'd5);
    write_reg(8'h04, 8'h21);
    write_reg(8'h08, 8'h21);
    ch_sel = 5;
    write_reg(8'h00, 8'h01);
    wait_wraps(2);
    chk("presc_period", last_gap, 40);
    chk("presc_high", last_hi, 20);
    write_reg(8'h15, 8'd0);
    wait_wraps(2);
    chk("duty0_period", last_gap, 40);
    chk("duty0_high", last_hi, 0);
    write_reg(8'h15, 8'd10);
    wait_wraps(2);
    chk("duty100_high", last_hi, 40);

    // Shadow commit: mid-period writes only take effect after the next wrap
    write_reg(8'h00, 8'h00);
    write_reg(8'h01, 8'd0);
    write_reg(8'h02, 8'd255);
    write_reg(8'h10, 8'd128);
    ch_sel = 0;
    write_reg(8'h00, 8'h01);
    wait_wraps(1);
    repeat (10) @(negedge clk);
    write_reg(8'h10, 8'd64);
    write_reg(8'h02, 8'd99);
    wait_wraps(1);
    chk("shadow_old_period", last_gap, 256);
    chk("shadow_old_high", last_hi, 128);
    wait_wraps(1);
    chk("shadow_new_period", last_gap, 100);
    chk("shadow_new_high", last_hi, 64);
    read_reg(8'h02, rd); chk("shadow_pend_rd", rd, 8'd99);

    // Reset mid-operation
    write_reg(8'h04, 8'h03);
    write_reg(8'h08, 8'h01);
    @(posedge clk); #1;
    chk("pre_rst_static", out[1], 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out", out, 0);
    chk("midrst_wrap", period_wrap, 0);
    @(negedge clk); rst = 1'b0;
    read_reg(8'h02, rd); chk("midrst_period", rd, 8'hFF);
    chk("midrst_out_after", out, 0);
    write_reg(8'h04, 8'h01);
    write_reg(8'h08, 8'h01);
    write_reg(8'h10, 8'd4);
    write_reg(8'h00, 8'h01);
    begin
      int k;
      for (k = 1; k <= 400; k++) begin
        @(posedge clk); #1;
        if (period_wrap) break;
      end
      chk("restart_first_wrap", k, 256);
      @(posedge clk); #1;
      chk("wrap_one_cycle", period_wrap, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
